// File: rtl/firewall_if.sv
// ----------------------------------------------------------------------------
// firewall_if
// Dibit stream bundle between the preamble/SFD stripper, the MAC filter and
// the downstream aggregator.
//   axiiv      : input dibit valid (high for the whole frame)
//   axiid      : input dibit, MSB-first
//   axiov      : filtered output dibit valid
//   axiod      : filtered output dibit (2'b00 whenever axiov is low)
//   drop_count : frames rejected on destination-MAC mismatch
// master drives the input stream and observes the results; slave is the filter.
// ----------------------------------------------------------------------------
interface firewall_if;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        axiov;
    logic [1:0]  axiod;
    logic [15:0] drop_count;

    modport master (
        output axiiv,
        output axiid,
        input  axiov,
        input  axiod,
        input  drop_count
    );

    modport slave (
        input  axiiv,
        input  axiid,
        output axiov,
        output axiod,
        output drop_count
    );
endinterface

// File: rtl/firewall.sv
// ----------------------------------------------------------------------------
// firewall
// Receive-side Ethernet MAC filter. Checks the destination MAC of each frame
// (dibits 0..23) against MAC_ADDR or broadcast, strips the 14-byte header
// (56 dibits) and forwards payload+FCS dibits of accepted frames one cycle
// later. Rejected frames are counted in a wrapping 16-bit drop counter.
// Ports:
//   clk : system clock (RMII domain)
//   rst : asynchronous active-high reset
//   bus : firewall_if.slave (axiiv/axiid in, axiov/axiod/drop_count out)
// ----------------------------------------------------------------------------
module firewall #(
    parameter logic [47:0] MAC_ADDR = 48'h69_69_5A_06_54_91
) (
    input  logic      clk,
    input  logic      rst,
    firewall_if.slave bus
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StHeader  = 2'd1;
    localparam logic [1:0] StForward = 2'd2;
    localparam logic [1:0] StDrop    = 2'd3;

    localparam logic [5:0] IdxDestLast = 6'd23;
    localparam logic [5:0] IdxHdrLast  = 6'd55;

    logic [1:0]  r_state;
    logic [5:0]  r_idx;
    logic        r_m_own;
    logic        r_m_bc;
    logic        r_axiov;
    logic [1:0]  r_axiod;
    logic [15:0] r_drop_count;

    logic [1:0]  w_state_d;
    logic [5:0]  w_idx_d;
    logic        w_m_own_d;
    logic        w_m_bc_d;
    logic        w_axiov_d;
    logic [1:0]  w_axiod_d;
    logic [15:0] w_drop_count_d;

    logic [1:0]  w_mac_dibit;
    logic        w_own_hit;
    logic        w_bc_hit;
    logic        w_own_keep;
    logic        w_bc_keep;

    // Expected address dibit for the current index; only meaningful for idx 0..23.
    assign w_mac_dibit = 2'(MAC_ADDR >> (7'd46 - {r_idx, 1'b0}));
    assign w_own_hit   = (bus.axiid == w_mac_dibit);
    assign w_bc_hit    = (bus.axiid == 2'b11);
    assign w_own_keep  = r_m_own & w_own_hit;
    assign w_bc_keep   = r_m_bc & w_bc_hit;

    always_comb begin
        w_state_d      = r_state;
        w_idx_d        = r_idx;
        w_m_own_d      = r_m_own;
        w_m_bc_d       = r_m_bc;
        w_axiov_d      = 1'b0;
        w_axiod_d      = 2'b00;
        w_drop_count_d = r_drop_count;

        if (!bus.axiiv) begin
            // Gap between frames: the only way out of DROP.
            w_state_d = StIdle;
            w_idx_d   = 6'd0;
            w_m_own_d = 1'b0;
            w_m_bc_d  = 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    // This dibit is idx 0 of a new frame.
                    w_state_d = StHeader;
                    w_idx_d   = 6'd1;
                    w_m_own_d = w_own_hit;
                    w_m_bc_d  = w_bc_hit;
                end
                StHeader: begin
                    if (r_idx <= IdxDestLast) begin
                        w_m_own_d = w_own_keep;
                        w_m_bc_d  = w_bc_keep;
                    end
                    if (r_idx == IdxDestLast && !w_own_keep && !w_bc_keep) begin
                        w_state_d      = StDrop;
                        w_idx_d        = 6'd0;
                        w_m_own_d      = 1'b0;
                        w_m_bc_d       = 1'b0;
                        w_drop_count_d = r_drop_count + 16'd1;
                    end else if (r_idx == IdxHdrLast) begin
                        w_state_d = StForward;
                        w_idx_d   = 6'd0;
                    end else begin
                        w_idx_d = r_idx + 6'd1;
                    end
                end
                StForward: begin
                    w_axiov_d = 1'b1;
                    w_axiod_d = bus.axiid;
                end
                default: begin
                    // StDrop: swallow dibits until axiiv falls.
                    w_state_d = StDrop;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StDrop;
            r_idx        <= 6'd0;
            r_m_own      <= 1'b0;
            r_m_bc       <= 1'b0;
            r_axiov      <= 1'b0;
            r_axiod      <= 2'b00;
            r_drop_count <= 16'd0;
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_m_own      <= w_m_own_d;
            r_m_bc       <= w_m_bc_d;
            r_axiov      <= w_axiov_d;
            r_axiod      <= w_axiod_d;
            r_drop_count <= w_drop_count_d;
        end
    end

    assign bus.axiov      = r_axiov;
    assign bus.axiod      = r_axiod;
    assign bus.drop_count = r_drop_count;

endmodule
